ddr3_dfi_sequencer: RTL and testbench
=====================================

// Module: ddr3_dfi_sequencer
// PURPOSE
//  Single-requester command sequencer for the generic DDR3 PHY (DFI side). Accepts DDR3 commands via valid/ready.
//  Enforces conservative global timing gaps, drives one-cycle DFI commands, and schedules write-strobe/data and read-enable windows.
//  Returns captured read bursts with a valid flag. Sits between the memory controller/AXI front-end and the PHY.
// PARAMETERS
//  DDR3_WIDTH 16 : DQ width; DFI data is 2*DDR3_WIDTH per clock.
//  DDR3_MASKS DDR3_WIDTH/8 : byte lanes; DFI mask is 2*DDR3_MASKS.
//  ADDR_BITS 14 : row/column address width.
//  WR_LATENCY 5 : cycles from dfi WRITE command to first dfi_wren_o (1..15).
//  RD_LATENCY 5 : cycles from dfi READ command to first dfi_rden_o (1..15).
//  RD_CAPTURE 2 : cycles from dfi_rden_o to PHY data valid on dfi_data_i (0..7).
//  BURST 4 : clocks per BL8 burst (fixed 4).
//  T_RCD 6, T_RP 6, T_RFC 64, T_MRD 4, T_WR 6, T_WTR 4, T_CCD 4 : minimum gaps in clocks.
// PORTS
//  clock        in  1  controller clock; same as PHY 'clock'.
//  reset_n      in  1  asynchronous, active-low reset.
//  cfg_cke_i    in  1  requested CKE level, from init logic.
//  cfg_rst_ni   in  1  requested DDR3 RESET# level.
//  cmd_valid_i  in  1  command request.
//  cmd_ready_o  out 1  command accepted when valid&ready.
//  cmd_code_i   in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 ZQCL.
//  cmd_bank_i   in  3  bank address.
//  cmd_addr_i   in  ADDR_BITS  row/col/MR value (A10 = auto-precharge ignored; must be 0).
//  wdat_ready_o out 1  write-data pull; high for BURST cycles per WR.
//  wdat_mask_i  in  2*DDR3_MASKS  byte-enables (1 = write), sampled when wdat_ready_o.
//  wdat_data_i  in  2*DDR3_WIDTH  write data, sampled when wdat_ready_o.
//  rdat_valid_o out 1  read beat-pair valid.
//  rdat_data_o  out 2*DDR3_WIDTH  read data.
//  dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o  out 1 each: PHY command pins.
//  dfi_bank_o   out 3; dfi_addr_o out ADDR_BITS.
//  dfi_wstb_o, dfi_wren_o  out 1; dfi_mask_o out 2*DDR3_MASKS (active-high enables); dfi_data_o out 2*DDR3_WIDTH.
//  dfi_rden_o   out 1; dfi_data_i in 2*DDR3_WIDTH  PHY read data.
// BEHAVIOUR
//  - Reset (async assert, sync release): cke=0, rst_n=0, cs_n=ras_n=cas_n=we_n=1, odt=0, bank/addr=0, wstb=wren=rden=0.
//    Also cmd_ready=0, wdat_ready=0, rdat_valid=0, all counters/pipes cleared, FSM=ST_RESET.
//    Reset mid-burst aborts it; no partial beats are emitted afterwards.
//  - FSM: ST_RESET -> ST_READY one cycle after release. ST_READY: accept -> ST_ISSUE. ST_ISSUE (1 cycle): drive cmd -> ST_WAIT.
//    ST_WAIT -> ST_READY when gap_cnt==0. cmd_ready_o=1 only in ST_READY and gate(cmd_code_i) true.
//  - Issue: registered; DFI command pins carry the command exactly in the cycle after acceptance.
//    Otherwise DFI is NOP (cs_n=0, ras_n=cas_n=we_n=1). NOP code is accepted but issues nothing, gap 0.
//  - gap_cnt load on accept: ACT T_RCD, PRE T_RP, REF T_RFC, MRS T_MRD, ZQCL 512, RD/WR T_CCD.
//  - Guards, independent down-counters, saturating at 0:
//    wtp_cnt = WR_LATENCY+BURST+T_WR, loaded on WR; blocks PRE/REF.
//    wtr_cnt = WR_LATENCY+BURST+T_WTR, loaded on WR; blocks RD.
//    rtw_cnt = RD_LATENCY+BURST+2, loaded on RD; blocks WR.
//  - Write pipe: wstb one cycle before wren; wren high BURST cycles starting WR_LATENCY after the dfi WRITE cycle.
//    wdat_ready_o is wren advanced one cycle. Data/mask are registered into dfi_data_o/dfi_mask_o aligned to wren.
//    odt high from dfi WRITE cycle through last wren cycle.
//  - Read pipe: rden high BURST cycles starting RD_LATENCY after dfi READ. rdat_valid_o = rden delayed RD_CAPTURE+1.
//    rdat_data_o = dfi_data_i registered. Exactly BURST valid beats per RD.
//  - Pipes are shift registers (length 16+BURST); back-to-back RD/RD or WR/WR at T_CCD give seamless bursts.
//  - cfg_cke_i/cfg_rst_ni registered straight to dfi_cke_o/dfi_rst_no; commands other than NOP held off while dfi_cke_o=0.
//  - Simultaneous guard expiry and request: counter==0 is evaluated on current value; accept same cycle it reads 0.
// STRUCTURE
//  - Shared package/include ddr3_defs: cmd code localparams, {cs_n,ras_n,cas_n,we_n} encodings per code, NOP encoding.
//  - One sub-module ddr3_burst_pipe (delay shift + BURST-wide window generator), instantiated for write and read.
//  - FSM, gap/guard counters and command register live in the top.
// TESTING
//  - Reset: hold reset_n=0 mid-write burst -> all outputs at reset values within 0 cycles; no wren after release.
//  - ACT(b2,row 0x123) then RD: RD ready exactly T_RCD=6 cycles after ACT accept.
//    dfi_rden 4 cycles from RD_LATENCY=5; rdat_valid 4 cycles, 3 cycles after rden.
//  - WR then PRE: wdat_ready 4 cycles; wren at +5 of dfi WRITE; odt covers WRITE..last wren; PRE ready at +15 after WR accept.
//  - WR then RD: RD held until wtr_cnt 0 (13 cycles); RD then WR held 11 cycles.
//  - RD,RD at T_CCD: rden high 8 contiguous cycles; 8 contiguous rdat_valid with data matching PHY model.
//  - REF: next ACT ready exactly 64 cycles later; cke=0 -> ACT never accepted, NOP still accepted.

Source files
------------

// File: rtl/ddr3_dfi_sequencer_pkg.sv
// ============================================================================
// ddr3_dfi_sequencer_pkg : DDR3 command codes and DFI pin encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package ddr3_dfi_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_REF  = 3'd5,
    CMD_MRS  = 3'd6,
    CMD_ZQCL = 3'd7
  } cmd_code_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] ENC_NOP  = 4'b0111;
  localparam logic [3:0] ENC_ACT  = 4'b0011;
  localparam logic [3:0] ENC_RD   = 4'b0101;
  localparam logic [3:0] ENC_WR   = 4'b0100;
  localparam logic [3:0] ENC_PRE  = 4'b0010;
  localparam logic [3:0] ENC_REF  = 4'b0001;
  localparam logic [3:0] ENC_MRS  = 4'b0000;
  localparam logic [3:0] ENC_ZQCL = 4'b0110;

  localparam int ZQCL_GAP = 512;

  function automatic logic [3:0] cmd_enc(input logic [2:0] code);
    case (code)
      CMD_ACT:  return ENC_ACT;
      CMD_RD:   return ENC_RD;
      CMD_WR:   return ENC_WR;
      CMD_PRE:  return ENC_PRE;
      CMD_REF:  return ENC_REF;
      CMD_MRS:  return ENC_MRS;
      CMD_ZQCL: return ENC_ZQCL;
      default:  return ENC_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_dfi_sequencer_burst_pipe.sv
// ============================================================================
// ddr3_dfi_sequencer_burst_pipe : delay shift register with BURST-wide window
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr3_dfi_sequencer_burst_pipe #(
  parameter int DEPTH   = 20,
  parameter int LATENCY = 5,
  parameter int BURST   = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_fire,
  output logic o_win,
  output logic o_span
);

  // Tap k is high k+1 cycles after i_fire, i.e. tap 0 is the DFI command cycle.
  localparam logic [DEPTH-1:0] c_win_mask  = {{(DEPTH-BURST){1'b0}}, {BURST{1'b1}}} << LATENCY;
  localparam logic [DEPTH-1:0] c_span_mask = c_win_mask | (c_win_mask - DEPTH'(1));

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_sr <= '0;
    else          r_sr <= {r_sr[DEPTH-2:0], i_fire};
  end

  assign o_win  = |(r_sr & c_win_mask);
  assign o_span = |(r_sr & c_span_mask);

endmodule

`default_nettype wire

// File: rtl/ddr3_dfi_sequencer.sv
// ============================================================================
// ddr3_dfi_sequencer : single-requester DDR3 DFI command sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr3_dfi_sequencer
  import ddr3_dfi_sequencer_pkg::*;
#(
  parameter int DDR3_WIDTH = 16,
  parameter int DDR3_MASKS = DDR3_WIDTH / 8,
  parameter int ADDR_BITS  = 14,
  parameter int WR_LATENCY = 5,
  parameter int RD_LATENCY = 5,
  parameter int RD_CAPTURE = 2,
  parameter int BURST      = 4,
  parameter int T_RCD      = 6,
  parameter int T_RP       = 6,
  parameter int T_RFC      = 64,
  parameter int T_MRD      = 4,
  parameter int T_WR       = 6,
  parameter int T_WTR      = 4,
  parameter int T_CCD      = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cfg_cke_i,
  input  logic                    cfg_rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [2:0]              cmd_code_i,
  input  logic [2:0]              cmd_bank_i,
  input  logic [ADDR_BITS-1:0]    cmd_addr_i,
  output logic                    wdat_ready_o,
  input  logic [2*DDR3_MASKS-1:0] wdat_mask_i,
  input  logic [2*DDR3_WIDTH-1:0] wdat_data_i,
  output logic                    rdat_valid_o,
  output logic [2*DDR3_WIDTH-1:0] rdat_data_o,
  output logic                    dfi_cke_o,
  output logic                    dfi_rst_no,
  output logic                    dfi_cs_no,
  output logic                    dfi_ras_no,
  output logic                    dfi_cas_no,
  output logic                    dfi_we_no,
  output logic                    dfi_odt_o,
  output logic [2:0]              dfi_bank_o,
  output logic [ADDR_BITS-1:0]    dfi_addr_o,
  output logic                    dfi_wstb_o,
  output logic                    dfi_wren_o,
  output logic [2*DDR3_MASKS-1:0] dfi_mask_o,
  output logic [2*DDR3_WIDTH-1:0] dfi_data_o,
  output logic                    dfi_rden_o,
  input  logic [2*DDR3_WIDTH-1:0] dfi_data_i
);

  localparam int DEPTH = 16 + BURST;
  localparam int RV_W  = RD_CAPTURE + 1;
  localparam int WTP   = WR_LATENCY + BURST + T_WR;
  localparam int WTR   = WR_LATENCY + BURST + T_WTR;
  localparam int RTW   = RD_LATENCY + BURST + 2;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]           r_state;
  logic [9:0]           r_gap;
  logic [7:0]           r_wtp, r_wtr, r_rtw;
  logic                 r_cke, r_rst_n;
  logic [3:0]           r_cmd;
  logic [2:0]           r_bank;
  logic [ADDR_BITS-1:0] r_addr;

  logic       w_gate, w_accept, w_issue, w_fire_wr, w_fire_rd;
  logic [9:0] w_gap_load;

  always_comb begin
    w_gate = r_cke;
    case (cmd_code_i)
      CMD_NOP:          w_gate = 1'b1;
      CMD_RD:           w_gate = r_cke && (r_wtr == '0);
      CMD_WR:           w_gate = r_cke && (r_rtw == '0);
      CMD_PRE, CMD_REF: w_gate = r_cke && (r_wtp == '0);
      default:          w_gate = r_cke;
    endcase
  end

  // Gap is loaded two short: ISSUE plus the WAIT->READY hop cover the rest,
  // so the next command can be accepted exactly T_x cycles after this one.
  always_comb begin
    w_gap_load = '0;
    case (cmd_code_i)
      CMD_ACT:        w_gap_load = 10'(T_RCD - 2);
      CMD_PRE:        w_gap_load = 10'(T_RP - 2);
      CMD_REF:        w_gap_load = 10'(T_RFC - 2);
      CMD_MRS:        w_gap_load = 10'(T_MRD - 2);
      CMD_ZQCL:       w_gap_load = 10'(ZQCL_GAP - 2);
      CMD_RD, CMD_WR: w_gap_load = 10'(T_CCD - 2);
      default:        w_gap_load = '0;
    endcase
  end

  assign cmd_ready_o = (r_state == ST_READY) && w_gate;
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_issue     = w_accept && (cmd_code_i != CMD_NOP);
  assign w_fire_wr   = w_accept && (cmd_code_i == CMD_WR);
  assign w_fire_rd   = w_accept && (cmd_code_i == CMD_RD);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_gap   <= '0;
      r_wtp   <= '0;
      r_wtr   <= '0;
      r_rtw   <= '0;
    end else begin
      case (r_state)
        ST_RESET: r_state <= ST_READY;
        ST_READY: if (w_accept) r_state <= ST_ISSUE;
        ST_ISSUE: r_state <= ST_WAIT;
        default:  if (r_gap == '0) r_state <= ST_READY;
      endcase

      if (w_accept)          r_gap <= w_gap_load;
      else if (r_gap != '0)  r_gap <= r_gap - 10'd1;

      // Guards reach zero exactly N cycles after the loading accept.
      if (w_fire_wr)         r_wtp <= 8'(WTP - 1);
      else if (r_wtp != '0)  r_wtp <= r_wtp - 8'd1;

      if (w_fire_wr)         r_wtr <= 8'(WTR - 1);
      else if (r_wtr != '0)  r_wtr <= r_wtr - 8'd1;

      if (w_fire_rd)         r_rtw <= 8'(RTW - 1);
      else if (r_rtw != '0)  r_rtw <= r_rtw - 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cke   <= 1'b0;
      r_rst_n <= 1'b0;
      r_cmd   <= 4'b1111;
      r_bank  <= '0;
      r_addr  <= '0;
    end else begin
      r_cke   <= cfg_cke_i;
      r_rst_n <= cfg_rst_ni;
      if (w_issue) begin
        r_cmd  <= cmd_enc(cmd_code_i);
        r_bank <= cmd_bank_i;
        r_addr <= cmd_addr_i;
      end else begin
        r_cmd  <= ENC_NOP;
        r_bank <= '0;
        r_addr <= '0;
      end
    end
  end

  assign dfi_cke_o  = r_cke;
  assign dfi_rst_no = r_rst_n;
  assign {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} = r_cmd;
  assign dfi_bank_o = r_bank;
  assign dfi_addr_o = r_addr;

  logic                    w_wr_pull, w_wr_span, w_rd_win, w_unused_rd_span;
  logic                    r_wren;
  logic [2*DDR3_MASKS-1:0] r_wmask;
  logic [2*DDR3_WIDTH-1:0] r_wdata;
  logic [RV_W-1:0]         r_rv;
  logic [2*DDR3_WIDTH-1:0] r_rdata;

  // The write window is generated one cycle early; wren is that window registered.
  ddr3_dfi_sequencer_burst_pipe #(
    .DEPTH   (DEPTH),
    .LATENCY (WR_LATENCY - 1),
    .BURST   (BURST)
  ) u_wr_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_fire  (w_fire_wr),
    .o_win   (w_wr_pull),
    .o_span  (w_wr_span)
  );

  ddr3_dfi_sequencer_burst_pipe #(
    .DEPTH   (DEPTH),
    .LATENCY (RD_LATENCY),
    .BURST   (BURST)
  ) u_rd_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_fire  (w_fire_rd),
    .o_win   (w_rd_win),
    .o_span  (w_unused_rd_span)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wren  <= 1'b0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_rv    <= '0;
      r_rdata <= '0;
    end else begin
      r_wren  <= w_wr_pull;
      r_wmask <= w_wr_pull ? wdat_mask_i : '0;
      if (w_wr_pull) r_wdata <= wdat_data_i;
      r_rv    <= (r_rv << 1) | RV_W'(w_rd_win);
      r_rdata <= dfi_data_i;
    end
  end

  assign wdat_ready_o = w_wr_pull;
  assign dfi_wstb_o   = w_wr_pull;
  assign dfi_wren_o   = r_wren;
  assign dfi_mask_o   = r_wmask;
  assign dfi_data_o   = r_wdata;
  assign dfi_odt_o    = w_wr_span | r_wren;
  assign dfi_rden_o   = w_rd_win;
  assign rdat_valid_o = r_rv[RD_CAPTURE];
  assign rdat_data_o  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_dfi_sequencer.sv
// ============================================================================
// tb_ddr3_dfi_sequencer : directed self-checking bench for ddr3_dfi_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr3_dfi_sequencer;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_REF = 3'd5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_cke_i, cfg_rst_ni, cmd_valid_i, cmd_ready_o;
  logic [2:0]  cmd_code_i, cmd_bank_i;
  logic [13:0] cmd_addr_i;
  logic        wdat_ready_o, rdat_valid_o;
  logic [3:0]  wdat_mask_i, dfi_mask_o;
  logic [31:0] wdat_data_i, rdat_data_o, dfi_data_o, dfi_data_i;
  logic        dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o;
  logic [2:0]  dfi_bank_o;
  logic [13:0] dfi_addr_o;
  logic        dfi_wstb_o, dfi_wren_o, dfi_rden_o;

  always #5 clock = ~clock;

  ddr3_dfi_sequencer dut (
    .clock(clock), .reset_n(reset_n), .cfg_cke_i(cfg_cke_i), .cfg_rst_ni(cfg_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_code_i(cmd_code_i),
    .cmd_bank_i(cmd_bank_i), .cmd_addr_i(cmd_addr_i), .wdat_ready_o(wdat_ready_o),
    .wdat_mask_i(wdat_mask_i), .wdat_data_i(wdat_data_i), .rdat_valid_o(rdat_valid_o),
    .rdat_data_o(rdat_data_o), .dfi_cke_o(dfi_cke_o), .dfi_rst_no(dfi_rst_no),
    .dfi_cs_no(dfi_cs_no), .dfi_ras_no(dfi_ras_no), .dfi_cas_no(dfi_cas_no),
    .dfi_we_no(dfi_we_no), .dfi_odt_o(dfi_odt_o), .dfi_bank_o(dfi_bank_o),
    .dfi_addr_o(dfi_addr_o), .dfi_wstb_o(dfi_wstb_o), .dfi_wren_o(dfi_wren_o),
    .dfi_mask_o(dfi_mask_o), .dfi_data_o(dfi_data_o), .dfi_rden_o(dfi_rden_o),
    .dfi_data_i(dfi_data_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-cycle log: bit0 rden, 1 rdat_valid, 2 wren, 3 wstb, 4 wdat_ready, 5 odt
  logic [7:0]  lg      [0:4095];
  logic [31:0] lg_rdat [0:4095];
  logic [31:0] lg_wdat [0:4095];
  logic [3:0]  lg_mask [0:4095];
  logic [20:0] lg_cmd  [0:4095];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cyc < 4096) begin
      lg[cyc]      = {2'b00, dfi_odt_o, wdat_ready_o, dfi_wstb_o, dfi_wren_o, rdat_valid_o, dfi_rden_o};
      lg_rdat[cyc] = rdat_data_o;
      lg_wdat[cyc] = dfi_data_o;
      lg_mask[cyc] = dfi_mask_o;
      lg_cmd[cyc]  = {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_bank_o, dfi_addr_o};
    end
    wdat_data_i = 32'hC0DE_0000 | 32'(cyc & 16'hFFFF);
    wdat_mask_i = 4'(cyc & 15);
    dfi_data_i  = 32'h5A5A_0000 | 32'(cyc & 16'hFFFF);
  end

  function automatic logic [31:0] fw(input int k);
    return 32'hC0DE_0000 | 32'(k & 16'hFFFF);
  endfunction

  function automatic logic [31:0] fd(input int k);
    return 32'h5A5A_0000 | 32'(k & 16'hFFFF);
  endfunction

  function automatic int cnt(input int b, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (lg[k][b] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first(input int b, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (lg[k][b] === 1'b1) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] code, input logic [2:0] bank, input logic [13:0] addr,
                       input int budget, output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    @(negedge clock);
    cmd_valid_i = 1'b1;
    cmd_code_i  = code;
    cmd_bank_i  = bank;
    cmd_addr_i  = addr;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (cmd_ready_o === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    cmd_valid_i = 1'b0;
  endtask

  task automatic send(input logic [2:0] code, input logic [2:0] bank, input logic [13:0] addr,
                      input string tag, output int acc);
    bit ok;
    issue(code, bank, addr, 600, acc, ok);
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int a, r, w, p, w2, rd2, rd3, f, a2, w3, rel, dummy;
    bit ok;
    cfg_cke_i = 1'b0; cfg_rst_ni = 1'b0; cmd_valid_i = 1'b0;
    cmd_code_i = '0; cmd_bank_i = '0; cmd_addr_i = '0;

    repeat (3) @(negedge clock);
    chk("rst_pins", {dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no,
                     dfi_odt_o, dfi_bank_o, dfi_addr_o}, {7'b0011110, 17'd0});
    chk("rst_hs", {cmd_ready_o, wdat_ready_o, rdat_valid_o, dfi_wren_o, dfi_wstb_o, dfi_rden_o}, 6'd0);

    reset_n = 1'b1; cfg_cke_i = 1'b1; cfg_rst_ni = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_nop", {dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no}, 6'b110111);

    // ACT -> RD -> WR -> PRE
    send(C_ACT, 3'd2, 14'h123, "act_acc", a);
    send(C_RD,  3'd2, 14'h010, "rd_acc",  r);
    chk("act_to_rd", 64'(r - a), 64'd6);
    send(C_WR,  3'd2, 14'h020, "wr_acc",  w);
    chk("rd_to_wr", 64'(w - r), 64'd11);
    send(C_PRE, 3'd2, 14'h000, "pre_acc", p);
    chk("wr_to_pre", 64'(p - w), 64'd15);
    repeat (30) @(negedge clock);

    chk("act_cmd", lg_cmd[a + 1], {4'b0011, 3'd2, 14'h123});
    chk("rd_cmd",  lg_cmd[r + 1], {4'b0101, 3'd2, 14'h010});
    chk("pre_cmd", lg_cmd[p + 1], {4'b0010, 3'd2, 14'h000});
    chk("rden_first",  64'(first(0, r + 1, r + 25)), 64'(r + 6));
    chk("rden_cnt",    64'(cnt(0, r + 1, r + 25)), 64'd4);
    chk("rvalid_first", 64'(first(1, r + 1, r + 25)), 64'(r + 9));
    chk("rvalid_cnt",  64'(cnt(1, r + 1, r + 25)), 64'd4);
    chk("rdat_beat0",  lg_rdat[r + 9], fd(r + 8));
    chk("rdat_beat3",  lg_rdat[r + 12], fd(r + 11));

    chk("wpull_first", 64'(first(4, w + 1, w + 30)), 64'(w + 5));
    chk("wpull_cnt",   64'(cnt(4, w + 1, w + 30)), 64'd4);
    chk("wstb_first",  64'(first(3, w + 1, w + 30)), 64'(w + 5));
    chk("wren_first",  64'(first(2, w + 1, w + 30)), 64'(w + 6));
    chk("wren_cnt",    64'(cnt(2, w + 1, w + 30)), 64'd4);
    chk("odt_first",   64'(first(5, w, w + 30)), 64'(w + 1));
    chk("odt_cnt",     64'(cnt(5, w, w + 30)), 64'd9);
    chk("wdat_beat0",  lg_wdat[w + 6], fw(w + 5));
    chk("wdat_beat3",  lg_wdat[w + 9], fw(w + 8));
    chk("wmask_beat1", 64'(lg_mask[w + 7]), 64'((w + 6) & 15));

    // WR -> RD -> RD back to back
    send(C_WR, 3'd1, 14'h040, "wr2_acc", w2);
    send(C_RD, 3'd1, 14'h040, "rd2_acc", rd2);
    chk("wr_to_rd", 64'(rd2 - w2), 64'd13);
    send(C_RD, 3'd1, 14'h048, "rd3_acc", rd3);
    chk("rd_to_rd", 64'(rd3 - rd2), 64'd4);
    repeat (30) @(negedge clock);
    chk("rr_rden_first", 64'(first(0, rd2 + 1, rd2 + 30)), 64'(rd2 + 6));
    chk("rr_rden_run",   64'(cnt(0, rd2 + 6, rd2 + 13)), 64'd8);
    chk("rr_rden_total", 64'(cnt(0, rd2 + 1, rd2 + 30)), 64'd8);
    chk("rr_rvalid_run", 64'(cnt(1, rd2 + 9, rd2 + 16)), 64'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_rdat%0d", k), lg_rdat[rd2 + 9 + k], fd(rd2 + 8 + k));

    // REF -> ACT
    send(C_REF, 3'd0, 14'h000, "ref_acc", f);
    send(C_ACT, 3'd3, 14'h0AA, "act2_acc", a2);
    chk("ref_to_act", 64'(a2 - f), 64'd64);
    repeat (10) @(negedge clock);

    // CKE low: ACT blocked, NOP accepted
    cfg_cke_i = 1'b0;
    repeat (3) @(negedge clock);
    issue(C_ACT, 3'd3, 14'h0AA, 20, dummy, ok);
    chk("cke0_act_blocked", 64'(ok), 64'd0);
    issue(C_NOP, 3'd0, 14'h000, 20, dummy, ok);
    chk("cke0_nop_acc", 64'(ok), 64'd1);

    // Reset in the middle of a write burst
    cfg_cke_i = 1'b1;
    repeat (3) @(negedge clock);
    send(C_WR, 3'd4, 14'h100, "wr3_acc", w3);
    while (cyc < w3 + 7) @(negedge clock);
    chk("mid_wren", 64'(dfi_wren_o), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_hs", {cmd_ready_o, wdat_ready_o, rdat_valid_o, dfi_wren_o, dfi_wstb_o,
                     dfi_rden_o, dfi_odt_o}, 7'd0);
    chk("abort_pins", {dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no,
                       dfi_bank_o, dfi_addr_o, dfi_mask_o}, {6'b001111, 21'd0});
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    repeat (20) @(negedge clock);
    chk("no_wren_after_rst", 64'(cnt(2, rel, rel + 18)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
